rhythm_sequencer: RTL and testbench
===================================

// Module: rhythm_sequencer
// PURPOSE
//  Game controller for the rhythm game. Sits between the debounced arrow buttons and
//  the seven-segment display driver. On each beat it picks a pseudo-random arrow and
//  opens a timed hit window. It then judges the player's press and keeps score and lives.
//  Its arrow_onehot output selects which display digit shows the arrow glyph.
// PARAMETERS
//  LFSR_SEED   8'hA5       initial LFSR value; a value of 0 is replaced by 8'h01
//  WINDOW_CYC  16'd50000   hit-window length in clk_in cycles, >=2 (bench uses 8)
//  LIVES_INIT  2'd3        lives loaded at game start, 1..3
//  SCORE_W     8           score width; score saturates at all-ones
// PORTS
//  clk_in        in   1        system clock
//  rst           in   1        synchronous reset, active-high
//  start         in   1        one-cycle start pulse; honoured only in IDLE or OVER
//  beat_tick     in   1        one-cycle beat pulse (from 2 Hz divider edge)
//  btn_up        in   1        debounced level, arrow index 0
//  btn_down      in   1        debounced level, arrow index 1
//  btn_left      in   1        debounced level, arrow index 2
//  btn_right     in   1        debounced level, arrow index 3
//  arrow_onehot  out  4        active arrow, bit i = arrow index i; 0 = none
//  score         out  SCORE_W  hits this game
//  lives         out  2        remaining lives
//  hit           out  1        one-cycle pulse on a correct judgement
//  miss          out  1        one-cycle pulse on a wrong, multiple or absent press
//  game_over     out  1        high while in OVER
// BEHAVIOUR
//  Reset: all state is synchronous to clk_in; rst wins over every other input.
//   While rst is high, or on the cycle after it deasserts: state=IDLE, arrow_onehot=0,
//   score=0, lives=0, hit=0, miss=0, game_over=0, LFSR=seed, button history=0.
//  Press detection: press[i] = btn_i & ~btn_i_q, registered history, 1-cycle latency.
//   A button held through start therefore never counts.
//  LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances once per accepted beat.
//   Arrow index = LFSR[1:0] sampled before the advance.
//  States:
//   IDLE  : outputs quiescent. On start: score<=0, lives<=LIVES_INIT, go to WAIT.
//   WAIT  : arrow_onehot=0; presses are ignored with no penalty.
//           On beat_tick: arrow_onehot<=1<<LFSR[1:0], LFSR advances,
//           wcnt<=WINDOW_CYC-1, go to WIN. The arrow is visible the cycle after the tick.
//   WIN   : arrow held; beat_tick ignored. Each cycle:
//           - any press: judge. Exactly the arrow bit pressed -> HIT; otherwise -> MISS.
//             Two or more simultaneous bits count as a miss.
//           - else if wcnt==0 -> MISS.
//           - else wcnt<=wcnt-1.
//           A press on the wcnt==0 cycle is judged; the press takes priority over timeout.
//   JUDGE : one cycle. hit or miss=1. arrow_onehot<=0.
//           On hit, score increments, saturating at all-ones.
//           On miss, lives decrements, not below 0.
//           Score and lives update on the same edge that raises the pulse.
//           Next state: OVER if lives becomes 0 on this miss, else WAIT.
//   OVER  : game_over=1, arrow_onehot=0, score frozen. On start: new game, as from IDLE.
//  start outside IDLE/OVER is ignored. hit and miss are never high together.
//  Pulses last exactly one cycle.
// STRUCTURE
//  Shared package game_pkg:
//   - state encodings IDLE/WAIT/WIN/JUDGE/OVER (3-bit)
//   - arrow index constants UP=0, DOWN=1, LEFT=2, RIGHT=3
//   - LFSR tap mask 8'hB8
//  One sub-module: btn_edge (4-bit level-to-press edge detector with registered history),
//  instantiated once.
//  The FSM, LFSR, window counter and score/lives registers stay in this module.
// TESTING  (WINDOW_CYC=8, LFSR_SEED=8'hA5, LIVES_INIT=3)
//  1 Reset, then start -> score=0, lives=3, arrow_onehot=0.
//    Then beat_tick -> arrow_onehot=4'b0010 on the next cycle (A5[1:0]=01).
//  2 From 1, rising btn_down 3 cycles after the arrow appears
//    -> hit for 1 cycle, score=1, arrow_onehot=0, back to WAIT.
//  3 Next beat, no press for 8 cycles -> miss pulse, lives=2, score stays 1.
//    Also: press landing on the final window cycle -> judged, not timed out.
//  4 Next beat, press the wrong button, or up+right in the same cycle
//    -> miss, lives decrements. A held button from before the window -> no press.
//  5 Third miss -> lives=0, game_over=1, beat_tick ignored.
//    Then start -> game_over=0, score=0, lives=3.
//  6 rst pulsed mid-WIN with arrow lit -> next cycle all outputs at reset values, IDLE.
//    Also: score preloaded near max saturates at 8'hFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the rhythm game: FSM state encoding, arrow indices,
// LFSR tap mask and the LFSR step function.
package game_pkg;

  // Game controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    WIN   = 3'd2,
    JUDGE = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Arrow indices; bit i of the one-hot arrow / press vectors
  localparam int unsigned UP         = 0;
  localparam int unsigned DOWN       = 1;
  localparam int unsigned LEFT       = 2;
  localparam int unsigned RIGHT      = 3;
  localparam int unsigned NUM_ARROWS = 4;

  localparam int unsigned LFSR_W = 8;

  // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // One Fibonacci step: shift left, feedback is the XOR of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Level-to-press edge detector for the debounced arrow buttons.
// A press is a registered rising edge: press[i] = btn[i] & ~btn_q[i], one cycle late.
// Ports:
//   clk_in  system clock
//   rst     synchronous active-high reset, clears history and presses
//   btn     debounced button levels, bit i = arrow index i
//   press   one-cycle press pulses, bit i = arrow index i
module btn_edge
  import game_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [NUM_ARROWS-1:0] btn,
  output logic [NUM_ARROWS-1:0] press
);

  logic [NUM_ARROWS-1:0] btn_q,   btn_d;
  logic [NUM_ARROWS-1:0] press_q, press_d;

  // Next history and edge detection
  always_comb begin
    btn_d   = btn;
    press_d = btn & ~btn_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      btn_q   <= '0;
      press_q <= '0;
    end else begin
      btn_q   <= btn_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/rhythm_sequencer.sv
// Rhythm game controller: on each beat picks a pseudo-random arrow, opens a
// timed hit window, judges the player's press and tracks score and lives.
// Ports:
//   clk_in        system clock
//   rst           synchronous active-high reset
//   start         one-cycle start pulse, honoured only in IDLE or OVER
//   beat_tick     one-cycle beat pulse
//   btn_up/down/left/right  debounced button levels (arrow index 0..3)
//   arrow_onehot  active arrow, bit i = arrow index i, 0 = none
//   score         hits this game, saturating
//   lives         remaining lives
//   hit / miss    one-cycle judgement pulses
//   game_over     high while in OVER
module rhythm_sequencer
  import game_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [15:0] WINDOW_CYC = 16'd50000,
  parameter logic [1:0]  LIVES_INIT = 2'd3,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  input  logic               beat_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic [3:0]         arrow_onehot,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic               game_over
);

  localparam int unsigned WCNT_W = 16;

  // An all-zero LFSR would lock up, so a zero seed is replaced
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t                state_q, state_d;
  logic [NUM_ARROWS-1:0] arrow_q, arrow_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [1:0]            lives_q, lives_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;
  logic                  game_over_q, game_over_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;

  logic [NUM_ARROWS-1:0] btn_lvl;
  logic [NUM_ARROWS-1:0] press;

  assign btn_lvl = {btn_right, btn_left, btn_down, btn_up};

  btn_edge u_btn_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .btn    (btn_lvl),
    .press  (press)
  );

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    arrow_d     = arrow_q;
    score_d     = score_q;
    lives_d     = lives_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    game_over_d = 1'b0;
    lfsr_d      = lfsr_q;
    wcnt_d      = wcnt_q;

    unique case (state_q)
      IDLE: begin
        arrow_d = '0;
        if (start) begin
          score_d = '0;
          lives_d = LIVES_INIT;
          state_d = WAIT;
        end
      end

      WAIT: begin
        arrow_d = '0;
        if (beat_tick) begin
          arrow_d = NUM_ARROWS'(1) << lfsr_q[1:0];
          lfsr_d  = lfsr_next(lfsr_q);
          wcnt_d  = WINDOW_CYC - WCNT_W'(1);
          state_d = WIN;
        end
      end

      // A press on the last window cycle wins over the timeout
      WIN: begin
        if (|press) begin
          arrow_d = '0;
          state_d = JUDGE;
          if (press == arrow_q) begin
            hit_d   = 1'b1;
            score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
          end else begin
            miss_d  = 1'b1;
            lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
          end
        end else if (wcnt_q == '0) begin
          arrow_d = '0;
          state_d = JUDGE;
          miss_d  = 1'b1;
          lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end

      // Pulse is visible here; lives already reflect the judgement
      JUDGE: begin
        arrow_d = '0;
        if (lives_q == 2'd0) begin
          state_d     = OVER;
          game_over_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end

      OVER: begin
        arrow_d     = '0;
        game_over_d = 1'b1;
        if (start) begin
          score_d     = '0;
          lives_d     = LIVES_INIT;
          state_d     = WAIT;
          game_over_d = 1'b0;
        end
      end

      default: begin
        arrow_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      arrow_q     <= '0;
      score_q     <= '0;
      lives_q     <= 2'd0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
      lfsr_q      <= SEED_EFF;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      arrow_q     <= arrow_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      game_over_q <= game_over_d;
      lfsr_q      <= lfsr_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign arrow_onehot = arrow_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_rhythm_sequencer.sv
// Scoreboard bench for rhythm_sequencer (WINDOW_CYC=8, seed A5, 3 lives).
// Expected judgements are queued by the stimulus; a negedge monitor pops and
// compares each time the DUT raises hit or miss.
module tb_rhythm_sequencer;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       start;
  logic       beat_tick;
  logic [3:0] btn;
  logic [3:0] arrow_onehot;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit;
  logic       miss;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       is_hit;
    logic [7:0] score;
    logic [1:0] lives;
  } exp_t;

  exp_t sb[$];

  rhythm_sequencer #(
    .LFSR_SEED  (8'hA5),
    .WINDOW_CYC (16'd8),
    .LIVES_INIT (2'd3),
    .SCORE_W    (8)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .start        (start),
    .beat_tick    (beat_tick),
    .btn_up       (btn[0]),
    .btn_down     (btn[1]),
    .btn_left     (btn[2]),
    .btn_right    (btn[3]),
    .arrow_onehot (arrow_onehot),
    .score        (score),
    .lives        (lives),
    .hit          (hit),
    .miss         (miss),
    .game_over    (game_over)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic tick();
    beat_tick = 1'b1;
    cyc();
    beat_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Raise buttons for one cycle; the judgement edge follows one cycle later
  task automatic press(input logic [3:0] b);
    btn = b;
    cyc();
    btn = 4'b0000;
    cyc();
  endtask

  task automatic push(input logic is_hit, input logic [7:0] sc, input logic [1:0] lv);
    exp_t e;
    e.is_hit = is_hit;
    e.score  = sc;
    e.lives  = lv;
    sb.push_back(e);
  endtask

  // Monitor: compare every judgement pulse against the next queued expectation
  always @(negedge clk_in) begin
    if (hit || miss) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b score=%0d lives=%0d", hit, miss, score, lives);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hit !== e.is_hit || miss !== !e.is_hit || score !== e.score || lives !== e.lives) begin
          n_errors++;
          $display("FAIL judgement: got hit=%0b miss=%0b score=%0d lives=%0d expected hit=%0b miss=%0b score=%0d lives=%0d",
                   hit, miss, score, lives, e.is_hit, !e.is_hit, e.score, e.lives);
        end
      end
    end
  end

  initial begin
    logic [3:0] a;
    rst = 1'b1; start = 1'b0; beat_tick = 1'b0; btn = 4'b0000;
    cyc(); cyc();
    chk("rst_arrow", 32'(arrow_onehot), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_lives", 32'(lives), 32'h0);
    chk("rst_game_over", 32'(game_over), 32'h0);
    chk("rst_pulses", 32'({hit, miss}), 32'h0);
    rst = 1'b0;
    cyc();
    chk("post_rst_lives", 32'(lives), 32'h0);

    pulse_start();
    chk("start_score", 32'(score), 32'h0);
    chk("start_lives", 32'(lives), 32'h3);
    chk("start_arrow", 32'(arrow_onehot), 32'h0);

    // Beat 1: LFSR A5 -> DOWN, hit 3 cycles after the arrow appears
    tick();
    chk("beat1_arrow", 32'(arrow_onehot), 32'h2);
    repeat (3) cyc();
    push(1'b1, 8'd1, 2'd3);
    press(4'b0010);
    cyc();
    chk("beat1_back_to_wait", 32'(arrow_onehot), 32'h0);

    // Beat 2: 4A -> LEFT, no press -> timeout miss after 8 window cycles
    tick();
    chk("beat2_arrow", 32'(arrow_onehot), 32'h4);
    push(1'b0, 8'd1, 2'd2);
    repeat (8) cyc();
    cyc();

    // Beat 3: 95 -> DOWN, press judged on the last window cycle
    tick();
    chk("beat3_arrow", 32'(arrow_onehot), 32'h2);
    repeat (6) cyc();
    push(1'b1, 8'd2, 2'd2);
    press(4'b0010);
    cyc();

    // Beat 4: 2A -> LEFT, correct button already held before the window -> timeout
    btn = 4'b0100;
    cyc();
    tick();
    chk("beat4_arrow", 32'(arrow_onehot), 32'h4);
    push(1'b0, 8'd2, 2'd1);
    repeat (8) cyc();
    cyc();
    btn = 4'b0000;
    cyc();

    // Beat 5: 54 -> UP, up+right together -> miss, last life gone
    tick();
    chk("beat5_arrow", 32'(arrow_onehot), 32'h1);
    push(1'b0, 8'd2, 2'd0);
    press(4'b1001);
    cyc();
    chk("over_game_over", 32'(game_over), 32'h1);
    chk("over_lives", 32'(lives), 32'h0);
    chk("over_score_frozen", 32'(score), 32'h2);
    tick();
    cyc();
    chk("over_tick_ignored", 32'(arrow_onehot), 32'h0);
    chk("over_still_over", 32'(game_over), 32'h1);

    pulse_start();
    chk("restart_game_over", 32'(game_over), 32'h0);
    chk("restart_score", 32'(score), 32'h0);
    chk("restart_lives", 32'(lives), 32'h3);

    // Beat 6: A9 -> DOWN, wrong button (LEFT)
    tick();
    chk("beat6_arrow", 32'(arrow_onehot), 32'h2);
    push(1'b0, 8'd0, 2'd2);
    press(4'b0100);
    cyc();

    // Beat 7: 53 -> RIGHT, hit
    tick();
    chk("beat7_arrow", 32'(arrow_onehot), 32'h8);
    push(1'b1, 8'd1, 2'd2);
    press(4'b1000);
    cyc();

    // Beat 8: A7 -> RIGHT, then reset while the arrow is lit
    tick();
    chk("beat8_arrow", 32'(arrow_onehot), 32'h8);
    rst = 1'b1;
    cyc();
    chk("midwin_rst_arrow", 32'(arrow_onehot), 32'h0);
    chk("midwin_rst_score", 32'(score), 32'h0);
    chk("midwin_rst_lives", 32'(lives), 32'h0);
    chk("midwin_rst_game_over", 32'(game_over), 32'h0);
    rst = 1'b0;
    cyc();
    tick();
    cyc();
    chk("idle_tick_ignored", 32'(arrow_onehot), 32'h0);

    // Score saturation: 257 consecutive hits, LFSR restarted from A5
    pulse_start();
    for (int i = 0; i < 257; i++) begin
      tick();
      a = arrow_onehot;
      if (i == 0) chk("sat_first_arrow", 32'(a), 32'h2);
      push(1'b1, (i >= 255) ? 8'hFF : 8'(i + 1), 2'd3);
      press(a);
      cyc();
    end
    chk("sat_score", 32'(score), 32'hFF);
    chk("sat_lives", 32'(lives), 32'h3);

    repeat (2) cyc();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
